ps2_transmitter: RTL

- Host-to-device PS/2 transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
- Runs on the system clock and oversamples the device-generated ps2_clk.
- Drives both PS/2 lines open-drain through output-enable pins.
- Sits beside the keyboard receiver; the receiver must ignore bus traffic while tx_busy=1.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_transmitter_if.sv | 38 +++
 rtl/ps2_sync_edge.sv | 42 ++++
 rtl/ps2_transmitter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the system-clocked PS/2 host blocks:
//   - tx_state_t      : host-to-device transmitter states
//   - PS2_FRAME_BITS  : start + 8 data + parity + stop
//   - odd_parity()    : parity bit that makes the 9-bit {parity,data} odd
//   - CMD_*           : common keyboard command bytes
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  // 1 when the byte holds an even number of ones, so that the total is odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_transmitter_if.sv
// ---------------------------------------------------------------------------
// ps2_transmitter_if
// Command handshake between a host controller and ps2_transmitter.
//   tx_data  : byte to send (master -> transmitter)
//   tx_start : send request, taken only while tx_ready=1
//   tx_ready : transmitter idle
//   tx_busy  : transfer in progress; a neighbouring receiver ignores the bus
//   tx_done  : one-cycle pulse, frame sent and acknowledged
//   tx_error : one-cycle pulse, timeout or missing acknowledge
// ---------------------------------------------------------------------------
interface ps2_transmitter_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output tx_error
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge
// detector in the system clock domain.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   async_in : raw line
//   sync_out : synchronized level
//   fall     : high for one cycle when sync_out goes 1 -> 0
// An input change becomes visible on fall after two flops, so logic that
// registers on fall reacts on the third clock edge.
// ---------------------------------------------------------------------------
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Reset to the idle (released, pulled-up) level so leaving reset never
  // produces a false falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync_out = sync_reg;
  assign fall     = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_transmitter
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard by
// inhibiting the bus, issuing request-to-send, shifting data on the falling
// edges of the device clock and checking the device acknowledge.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   host         : command handshake (ps2_transmitter_if.slave)
//   ps2_clk_in   : raw PS/2 clock line
//   ps2_data_in  : raw PS/2 data line
//   ps2_clk_oe   : 1 pulls the clock line low, 0 releases it
//   ps2_data_oe  : 1 pulls the data line low, 0 releases it
// The device clock is only oversampled; nothing is clocked on it.
// ---------------------------------------------------------------------------
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2_transmitter_if.slave host,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe
);

  localparam int INHIBIT_CYC = (CLK_FREQ_HZ / 1000000) * INHIBIT_US;
  localparam int TIMEOUT_CYC = (CLK_FREQ_HZ / 1000000) * TIMEOUT_US;
  localparam int TIMER_MAX   = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TIMER_W     = $clog2(TIMER_MAX + 1);
  // Bits shifted after the start bit: 8 data, parity, stop.
  localparam int SHIFT_BITS  = PS2_FRAME_BITS - 1;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]         SHIFT_LAST   = 4'(SHIFT_BITS - 1);

  // ---------------- line synchronizers ----------------
  logic clk_sync;
  logic clk_fall;

  ps2_sync_edge u_clk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ps2_clk_in),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  // Data needs the same two-flop latency as the clock so that the level
  // sampled on a detected clock fall matches the line at that fall.
  logic data_meta_reg;
  logic data_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      data_meta_reg <= ps2_data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  // ---------------- transmit FSM ----------------
  tx_state_t                state_reg,   state_next;
  logic [TIMER_W-1:0]       timer_reg,   timer_next;
  logic [3:0]               bit_cnt_reg, bit_cnt_next;
  logic [SHIFT_BITS-1:0]    frame_reg,   frame_next;
  logic                     ack_reg,     ack_next;
  logic                     clk_oe_reg,  clk_oe_next;
  logic                     data_oe_reg, data_oe_next;
  logic                     done_reg,    done_next;
  logic                     error_reg,   error_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      frame_reg   <= '0;
      ack_reg     <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      frame_reg   <= frame_next;
      ack_reg     <= ack_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  logic timer_expired;
  assign timer_expired = (timer_reg == TIMEOUT_LAST);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    frame_next   = frame_reg;
    ack_next     = ack_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (host.tx_start) begin
          frame_next   = {1'b1, odd_parity(host.tx_data), host.tx_data};
          timer_next   = '0;
          bit_cnt_next = '0;
          ack_next     = 1'b0;
          clk_oe_next  = 1'b1;
          state_next   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (timer_reg == INHIBIT_LAST) begin
          data_oe_next = 1'b1;          // start bit
          timer_next   = '0;
          state_next   = ST_RTS;
        end
      end

      ST_RTS: begin
        timer_next   = timer_reg + TIMER_W'(1);
        clk_oe_next  = 1'b0;            // hand the clock to the device
        bit_cnt_next = '0;
        state_next   = ST_SHIFT;
      end

      ST_SHIFT: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (clk_fall) begin
          timer_next   = '0;
          // Frame holds the stop bit (1) last, so the final edge releases data.
          data_oe_next = ~frame_reg[0];
          frame_next   = {1'b1, frame_reg[SHIFT_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == SHIFT_LAST) begin
            state_next = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (clk_fall) begin
          timer_next = '0;
          ack_next   = ~data_sync_reg;
          state_next = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (clk_sync && data_sync_reg) begin
          done_next  = ack_reg;
          error_next = ~ack_reg;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
      end
    endcase

    // A device edge or normal completion in the same cycle takes priority
    // over the watchdog, which only fires when nothing else moved the FSM.
    if ((state_reg == ST_RTS || state_reg == ST_SHIFT ||
         state_reg == ST_ACK || state_reg == ST_WAIT_IDLE) &&
        timer_expired && !clk_fall && state_next != ST_IDLE) begin
      state_next   = ST_IDLE;
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b0;
      error_next   = 1'b1;
    end
  end

  assign host.tx_ready = (state_reg == ST_IDLE);
  assign host.tx_busy  = (state_reg != ST_IDLE);
  assign host.tx_done  = done_reg;
  assign host.tx_error = error_reg;
  assign ps2_clk_oe    = clk_oe_reg;
  assign ps2_data_oe   = data_oe_reg;

endmodule
